// File: rtl/norm_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : norm_pkg
//  Purpose  : Shared constants and the row-pair entry layout used by the
//             normalization collector and its row FIFO.
//  Contents : COL, BW_PSUM, BW_OUT, ADDR_W defaults; row_pair_t entry type.
//  Revision : 1.0 - initial release
// ============================================================================
package norm_pkg;

    // Default geometry of the collector.
    localparam int COL     = 8;   // elements per row
    localparam int BW_PSUM = 16;  // width of an incoming normalized value
    localparam int BW_OUT  = 8;   // width of a saturated output element
    localparam int ADDR_W  = 8;   // width of the row address

    // One FIFO entry at the default geometry. Row lanes are packed with
    // element 0 in the least-significant byte; the address sits on top.
    typedef struct packed {
        logic [ADDR_W-1:0]     addr;
        logic [COL*BW_OUT-1:0] row_2;
        logic [COL*BW_OUT-1:0] row_1;
    } row_pair_t;

endpackage : norm_pkg
`default_nettype wire

// File: rtl/norm_row_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : norm_row_fifo
//  Purpose  : Synchronous first-word-fall-through FIFO holding completed row
//             pairs. The head entry is visible on head_data whenever the FIFO
//             is not empty.
//  Ports    : clk, reset      - clock, synchronous active-high reset
//             push, push_data - write request and entry
//             pop             - remove head (ignored while empty)
//             head_data       - current head entry
//             full, empty     - occupancy status
//  Revision : 1.0 - initial release
// ============================================================================
module norm_row_fifo
    import norm_pkg::*;
#(
    parameter int WIDTH = 2 * norm_pkg::COL * norm_pkg::BW_OUT + norm_pkg::ADDR_W,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    // Popping an empty FIFO is a no-op; a push into a full FIFO is legal
    // only when the head leaves in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is deliberately left without reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign head_data = mem[rd_ptr];

endmodule : norm_row_fifo
`default_nettype wire

// File: rtl/norm_collector.sv
`default_nettype none
// ============================================================================
//  Module   : norm_collector
//  Purpose  : Deserializes two streams of normalized values into rows of COL
//             saturated elements, tags each completed row pair with a running
//             address and queues it in a FWFT FIFO for a valid/ready consumer.
//  Ports    : clk, reset                  - clock, synchronous active-high reset
//             norm_valid                  - one element of each stream present
//             psum_norm_1, psum_norm_2    - unsigned stream elements
//             m_ready / m_valid           - row-pair handshake
//             m_data_1, m_data_2          - head row pair, lane 0 in LSBs
//             m_addr                      - address of the head row pair
//             overflow                    - sticky: a completed row was dropped
//  Revision : 1.0 - initial release
// ============================================================================
module norm_collector
    import norm_pkg::*;
#(
    parameter int BW_IN  = norm_pkg::BW_PSUM,
    parameter int COL    = norm_pkg::COL,
    parameter int BW_OUT = norm_pkg::BW_OUT,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = norm_pkg::ADDR_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  norm_valid,
    input  logic [BW_IN-1:0]      psum_norm_1,
    input  logic [BW_IN-1:0]      psum_norm_2,
    input  logic                  m_ready,
    output logic                  m_valid,
    output logic [COL*BW_OUT-1:0] m_data_1,
    output logic [COL*BW_OUT-1:0] m_data_2,
    output logic [ADDR_W-1:0]     m_addr,
    output logic                  overflow
);

    localparam int IDX_W = $clog2(COL);

    // Entry layout for this instance's geometry (same ordering as row_pair_t).
    typedef struct packed {
        logic [ADDR_W-1:0]     addr;
        logic [COL*BW_OUT-1:0] row_2;
        logic [COL*BW_OUT-1:0] row_1;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

    logic [IDX_W-1:0]             idx;
    logic [ADDR_W-1:0]            addr_cnt;
    logic [COL-1:0][BW_OUT-1:0]   asm_1;
    logic [COL-1:0][BW_OUT-1:0]   asm_2;
    logic [COL-1:0][BW_OUT-1:0]   row_1;
    logic [COL-1:0][BW_OUT-1:0]   row_2;
    logic [BW_OUT-1:0]            sat_1;
    logic [BW_OUT-1:0]            sat_2;
    logic                         row_done;
    logic                         pop_req;
    logic                         push_ok;
    logic                         fifo_full;
    logic                         fifo_empty;
    entry_t                       push_entry;
    entry_t                       head_entry;
    logic [ENTRY_W-1:0]           head_bits;

    // ------------------------------------------------------------------
    // Saturation: clip to the largest BW_OUT-bit value. When the input is
    // no wider than the output nothing can overflow.
    // ------------------------------------------------------------------
    generate
        if (BW_IN > BW_OUT) begin : g_sat_clip
            assign sat_1 = (|psum_norm_1[BW_IN-1:BW_OUT]) ? {BW_OUT{1'b1}}
                                                          : psum_norm_1[BW_OUT-1:0];
            assign sat_2 = (|psum_norm_2[BW_IN-1:BW_OUT]) ? {BW_OUT{1'b1}}
                                                          : psum_norm_2[BW_OUT-1:0];
        end else begin : g_sat_pass
            assign sat_1 = BW_OUT'(psum_norm_1);
            assign sat_2 = BW_OUT'(psum_norm_2);
        end
    endgenerate

    assign row_done = norm_valid && (idx == IDX_W'(COL - 1));
    assign pop_req  = m_valid && m_ready;
    // A full FIFO still takes the row when its head leaves this cycle.
    assign push_ok  = row_done && (!fifo_full || pop_req);

    // ------------------------------------------------------------------
    // Index, address counter and sticky overflow.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            idx      <= '0;
            addr_cnt <= '0;
            overflow <= 1'b0;
        end else begin
            if (norm_valid) begin
                idx <= row_done ? '0 : idx + 1'b1;
            end
            if (push_ok) begin
                addr_cnt <= addr_cnt + 1'b1;
            end
            if (row_done && !push_ok) begin
                overflow <= 1'b1;
            end
        end
    end

    // Assembly registers carry no reset: a stale lane is always overwritten
    // before its row can complete.
    always_ff @(posedge clk) begin
        if (norm_valid) begin
            asm_1[idx] <= sat_1;
            asm_2[idx] <= sat_2;
        end
    end

    // The last element is still on the inputs when the row completes, so it
    // is merged combinationally into the pushed entry.
    always_comb begin
        row_1        = asm_1;
        row_2        = asm_2;
        row_1[COL-1] = sat_1;
        row_2[COL-1] = sat_2;
    end

    always_comb begin
        push_entry       = '0;
        push_entry.row_1 = row_1;
        push_entry.row_2 = row_2;
        push_entry.addr  = addr_cnt;
    end

    norm_row_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_row_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (row_done),
        .push_data (push_entry),
        .pop       (pop_req),
        .head_data (head_bits),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign head_entry = entry_t'(head_bits);

    assign m_valid  = !fifo_empty;
    assign m_data_1 = head_entry.row_1;
    assign m_data_2 = head_entry.row_2;
    // Forced to zero while empty so the address is defined out of reset.
    assign m_addr   = fifo_empty ? '0 : head_entry.addr;

endmodule : norm_collector
`default_nettype wire

// File: doc/norm_collector.md
NORM_COLLECTOR -- requirements
Module: norm_collector

Interface
REQ-001 SHALL have parameter BW_IN, default 16, meaning the width of each incoming normalized value.
REQ-002 SHALL have parameter COL, default 8, meaning the number of elements per row (a power of two, at least 2).
REQ-003 SHALL have parameter BW_OUT, default 8, meaning the width of each saturated output element.
REQ-004 SHALL have parameter DEPTH, default 4, meaning the number of row-pair FIFO entries (a power of two).
REQ-005 SHALL have parameter ADDR_W, default 8, meaning the width of the output row address.
REQ-006 SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-007 SHALL have port reset, input, 1 bit, a synchronous active-high reset.
REQ-008 SHALL have port norm_valid, input, 1 bit, meaning element k of the current row is present this cycle.
REQ-009 SHALL have port psum_norm_1, input, BW_IN bits, the stream-1 element (unsigned).
REQ-010 SHALL have port psum_norm_2, input, BW_IN bits, the stream-2 element (unsigned).
REQ-011 SHALL have port m_ready, input, 1 bit, meaning the downstream accepts a row pair.
REQ-012 SHALL have port m_valid, output, 1 bit, meaning a row pair is available.
REQ-013 SHALL have port m_data_1, output, COL x BW_OUT bits, the stream-1 row with element 0 in the least-significant lane.
REQ-014 SHALL have port m_data_2, output, COL x BW_OUT bits, the stream-2 row with the same lane ordering as m_data_1.
REQ-015 SHALL have port m_addr, output, ADDR_W bits, the row address attached to the head row pair.
REQ-016 SHALL have port overflow, output, 1 bit, a sticky flag meaning a completed row was dropped.

Function
REQ-017 SHALL treat the elements on consecutive norm_valid cycles as indices 0..COL-1 of one row, tracked by an index counter.
REQ-018 SHALL hold the index counter on norm_valid=0 cycles, so gaps mid-row are legal and have no timeout.
REQ-019 SHALL saturate each element before storing it: min(value, 2^BW_OUT-1).
- Example: with BW_OUT=8, 256 becomes 255 and 37 stays 37.
REQ-020 SHALL write the saturated elements into lane index of the assembly registers for stream 1 and stream 2 in parallel.
REQ-021 SHALL mark the row complete when norm_valid=1 and index=COL-1.
- On completion the index wraps to 0.
- The completed row pair plus the current address counter are pushed into the FIFO.
REQ-022 SHALL accept the push when the FIFO is not full, or when it is full and a pop happens in the same cycle.
REQ-023 SHALL otherwise drop the completed row and set overflow to 1.
- overflow stays 1 until reset.
- A dropped row does not advance the address counter.
REQ-024 SHALL increment the address counter by 1 per accepted row, modulo 2^ADDR_W (0xFF wraps to 0x00 with the defaults).
REQ-025 SHALL present the FIFO as first-word-fall-through.
- m_valid = FIFO not empty.
- m_data_1, m_data_2 and m_addr show the head entry.
REQ-026 SHALL pop the head entry on m_valid && m_ready, and ignore m_ready when m_valid=0.
REQ-027 SHALL keep m_data_1, m_data_2 and m_addr stable while m_valid=1 and m_ready=0.
REQ-028 SHALL raise m_valid on the cycle after the completing norm_valid cycle when the FIFO was empty (latency 1).
REQ-029 SHALL allow a push into an empty FIFO and a pop in the same cycle without loss.
- Only non-empty entries are ever popped.
REQ-030 SHALL sustain one row per COL cycles indefinitely while m_ready=1, with no drops.

Reset
REQ-031 SHALL, when reset=1, clear the index, address counter, FIFO pointers and occupancy, and overflow to 0 on the next edge.
REQ-032 SHALL drive m_valid=0, m_addr=0 and overflow=0 out of reset; m_data_1 and m_data_2 are don't-care while m_valid=0.
REQ-033 SHALL discard a partially assembled row when reset arrives mid-row; the first norm_valid after reset is element 0.
REQ-034 SHALL leave the data storage and assembly registers un-reset.

Structure
REQ-035 SHALL import the shared package norm_pkg, which holds:
- the default constants COL, BW_PSUM and BW_OUT;
- the row-pair entry typedef (two COL x BW_OUT rows plus an ADDR_W address).
REQ-036 SHALL instantiate one sub-module, norm_row_fifo: a synchronous FWFT FIFO parameterized by entry width and DEPTH, with push, pop, full and empty.
REQ-037 SHALL keep the deserializer, saturation and address counter in norm_collector itself.

Verification
REQ-038 SHALL check single row: 8 valid cycles with stream-1 values 0,1..7 and stream-2 values 256,255,0,.. with m_ready=1 -> m_valid exactly 1 cycle later; m_data_1 lanes 0..7 = 0..7; m_data_2 lane0=255, lane1=255; m_addr=0.
REQ-039 SHALL check gaps: the same row with norm_valid toggling 1/0 -> identical m_data to the gapless case; m_valid 1 cycle after the 8th valid.
REQ-040 SHALL check backpressure and overflow (DEPTH=4): m_ready=0 during 5 rows -> 4 entries held with addresses 0..3 and overflow=1; then m_ready=1 -> 4 pops in order; the 6th row gets address 4.
REQ-041 SHALL check full with simultaneous pop: FIFO full and the completing element coincides with m_ready=1 -> no drop, overflow stays 0, occupancy stays 4.
REQ-042 SHALL check reset mid-row: reset after 3 elements, then 8 new elements -> one row with the new values only, m_addr=0.
REQ-043 SHALL check address wrap (ADDR_W=2): 5 accepted rows -> addresses 0,1,2,3,0.
